// File: rtl/codma_pkg.sv
// Shared CODMA definitions: responder state encoding, burst size codes and
// the size-code to beat-count mapping used by both engine and memory sides.
package codma_pkg;

  typedef enum logic [2:0] {
    RSP_IDLE,
    RSP_READ,
    RSP_RDRAIN,
    RSP_WRITE,
    RSP_RESP,
    RSP_ERR
  } rsp_state_t;

  localparam logic [7:0] SIZE_8B  = 8'd3;
  localparam logic [7:0] SIZE_16B = 8'd8;
  localparam logic [7:0] SIZE_32B = 8'd9;

  localparam int RSP_WORDS = 8;

  // Zero marks an unsupported size code.
  function automatic logic [3:0] size_to_beats(input logic [7:0] size);
    case (size)
      SIZE_8B:  return 4'd2;
      SIZE_16B: return 4'd4;
      SIZE_32B: return 4'd8;
      default:  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/codma_req_check.sv
// Combinational burst request checker: beat count, alignment and range
// against a memory of 2^MEM_AW 32-bit words starting at byte 0.
module codma_req_check
  import codma_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic [31:0] addr,
  input  logic [7:0]  size,
  output logic [3:0]  beats,
  output logic        error
);

  logic [32:0] end_word;
  logic [32:0] mem_words;

  // 33-bit sum so a start address near 4 GiB cannot wrap into range.
  always_comb begin
    beats     = size_to_beats(size);
    end_word  = {3'b000, addr[31:2]} + {29'd0, beats};
    mem_words = 33'd1 << MEM_AW;
    error     = (beats == 4'd0) || (addr[1:0] != 2'b00) || (end_word > mem_words);
  end

endmodule

// File: rtl/codma_mem_responder.sv
// Memory-side responder for CODMA bursts: runs one checked read or write
// burst against a single-port synchronous SRAM and returns a one-cycle response.
module codma_mem_responder
  import codma_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [31:0]           req_addr_i,
  input  logic [7:0]            req_size_i,
  input  logic [7:0][31:0]      req_wdata_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_error_o,
  output logic [7:0][31:0]      rsp_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  rsp_state_t            state, state_nxt;
  logic [2:0]            beat_cnt, beat_cnt_nxt;
  logic [3:0]            n_beats;
  logic [MEM_AW-1:0]     base_addr;
  logic [7:0][31:0]      wbuf;
  logic [3:0]            chk_beats;
  logic                  chk_error;
  logic                  accept;
  logic                  last_beat;

  logic                  ready_nxt, valid_nxt, error_nxt, en_nxt, we_nxt;
  logic [MEM_AW-1:0]     addr_nxt;
  logic [31:0]           wdata_nxt;

  codma_req_check #(.MEM_AW(MEM_AW)) u_check (
    .addr  (req_addr_i),
    .size  (req_size_i),
    .beats (chk_beats),
    .error (chk_error)
  );

  assign accept    = req_valid_i && req_ready_o;
  assign last_beat = ({1'b0, beat_cnt} == (n_beats - 4'd1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= RSP_IDLE;
      beat_cnt    <= 3'd0;
      n_beats     <= 4'd0;
      base_addr   <= '0;
      wbuf        <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_error_o <= 1'b0;
      rsp_rdata_o <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state       <= state_nxt;
      beat_cnt    <= beat_cnt_nxt;
      req_ready_o <= ready_nxt;
      rsp_valid_o <= valid_nxt;
      rsp_error_o <= error_nxt;
      mem_en_o    <= en_nxt;
      mem_we_o    <= we_nxt;
      mem_addr_o  <= addr_nxt;
      mem_wdata_o <= wdata_nxt;
      if (accept && !chk_error) begin
        base_addr <= req_addr_i[MEM_AW+1:2];
        n_beats   <= chk_beats;
        wbuf      <= req_wdata_i;
        if (!req_write_i) begin
          for (int k = 0; k < RSP_WORDS; k++) begin
            if (k >= int'(chk_beats)) rsp_rdata_o[k] <= '0;
          end
        end
      end
      // SRAM data lags its address by one cycle, so capture trails issue by one beat.
      if (state == RSP_READ && beat_cnt != 3'd0) begin
        rsp_rdata_o[beat_cnt - 3'd1] <= mem_rdata_i;
      end
      if (state == RSP_RDRAIN) begin
        rsp_rdata_o[n_beats[2:0] - 3'd1] <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RSP_IDLE: begin
        if (accept) begin
          if (chk_error)        state_nxt = RSP_ERR;
          else if (req_write_i) state_nxt = RSP_WRITE;
          else                  state_nxt = RSP_READ;
        end
      end
      RSP_READ:   if (last_beat) state_nxt = RSP_RDRAIN;
      RSP_RDRAIN: state_nxt = RSP_RESP;
      RSP_WRITE:  if (last_beat) state_nxt = RSP_RESP;
      RSP_RESP:   state_nxt = RSP_IDLE;
      RSP_ERR:    state_nxt = RSP_IDLE;
      default:    state_nxt = RSP_IDLE;
    endcase
  end

  always_comb begin
    ready_nxt    = 1'b0;
    valid_nxt    = 1'b0;
    error_nxt    = 1'b0;
    en_nxt       = 1'b0;
    we_nxt       = 1'b0;
    addr_nxt     = mem_addr_o;
    wdata_nxt    = mem_wdata_o;
    beat_cnt_nxt = beat_cnt;
    case (state)
      RSP_IDLE: begin
        ready_nxt = 1'b1;
        if (accept) begin
          ready_nxt = 1'b0;
          if (chk_error) begin
            valid_nxt = 1'b1;
            error_nxt = 1'b1;
          end else begin
            en_nxt       = 1'b1;
            we_nxt       = req_write_i;
            addr_nxt     = req_addr_i[MEM_AW+1:2];
            wdata_nxt    = req_wdata_i[0];
            beat_cnt_nxt = 3'd0;
          end
        end
      end
      RSP_READ, RSP_WRITE: begin
        if (last_beat) begin
          valid_nxt = (state == RSP_WRITE);
        end else begin
          en_nxt       = 1'b1;
          we_nxt       = (state == RSP_WRITE);
          beat_cnt_nxt = beat_cnt + 3'd1;
          addr_nxt     = base_addr + MEM_AW'(beat_cnt) + MEM_AW'(1);
          wdata_nxt    = wbuf[beat_cnt + 3'd1];
        end
      end
      RSP_RDRAIN: valid_nxt = 1'b1;
      RSP_RESP, RSP_ERR: ready_nxt = 1'b1;
      default: ready_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_codma_mem_responder.sv
// Directed bench for codma_mem_responder with a behavioural synchronous SRAM.
module tb_codma_mem_responder;

  localparam int MEM_AW = 10;
  localparam int DEPTH  = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready_o;
  logic              req_write = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [7:0]        req_size = '0;
  logic [7:0][31:0]  req_wdata = '0;
  logic              rsp_valid_o;
  logic              rsp_error_o;
  logic [7:0][31:0]  rsp_rdata_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata = '0;

  always #5 clk = ~clk;

  codma_mem_responder #(.MEM_AW(MEM_AW)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_size_i  (req_size),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid_o),
    .rsp_error_o (rsp_error_o),
    .rsp_rdata_o (rsp_rdata_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata)
  );

  logic [31:0] sram [DEPTH];
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata <= sram[mem_addr_o];
    end
  end

  int checks = 0;
  int errors = 0;

  // Per-request observations; cycle c is the cycle after accept edge E(c-1).
  int                vcycle;
  logic              verr;
  int                en_cnt, we_cnt;
  logic [MEM_AW-1:0] addr_log[$];
  logic [31:0]       wd_log[$];
  logic              busy_ready, stray_err, ready_after;

  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [7:0] size,
                         input logic [7:0][31:0] wd);
    int t;
    vcycle = 0; verr = 0; en_cnt = 0; we_cnt = 0;
    addr_log.delete(); wd_log.delete();
    busy_ready = 0; stray_err = 0; ready_after = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size; req_wdata = wd;
    t = 0;
    while (!req_ready_o && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL accept_wait: req_ready_o=%0b required 1", req_ready_o);
    end
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (mem_en_o) begin
        en_cnt++;
        addr_log.push_back(mem_addr_o);
        if (mem_we_o) begin we_cnt++; wd_log.push_back(mem_wdata_o); end
      end
      if (rsp_error_o && !rsp_valid_o) stray_err = 1'b1;
      if (vcycle != 0) begin ready_after = req_ready_o; break; end
      if (req_ready_o) busy_ready = 1'b1;
      if (rsp_valid_o) begin vcycle = c; verr = rsp_error_o; end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", req_ready_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", rsp_valid_o); end
    checks++; if (rsp_error_o !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b want 0", rsp_error_o); end
    checks++; if (mem_en_o !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b want 0", mem_en_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", mem_we_o); end
    checks++; if (mem_addr_o !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
    checks++; if (mem_wdata_o !== '0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata_o); end
    checks++; if (rsp_rdata_o !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata_o); end
    reset_n = 1'b1;
  endtask

  task automatic test_write_burst;
    logic [7:0][31:0] wd;
    for (int k = 0; k < 8; k++) wd[k] = 32'hC0DE_0000 + k;
    run_req(1'b1, 32'h100, 8'd9, wd);
    checks++; if (vcycle !== 9) begin errors++; $display("FAIL wr_valid_cycle: got %0d want 9", vcycle); end
    checks++; if (verr !== 1'b0) begin errors++; $display("FAIL wr_error: got %0b want 0", verr); end
    checks++; if (we_cnt !== 8) begin errors++; $display("FAIL wr_we_count: got %0d want 8", we_cnt); end
    checks++; if (en_cnt !== 8) begin errors++; $display("FAIL wr_en_count: got %0d want 8", en_cnt); end
    checks++; if (busy_ready !== 1'b0) begin errors++; $display("FAIL wr_busy_ready: got %0b want 0", busy_ready); end
    checks++; if (stray_err !== 1'b0) begin errors++; $display("FAIL wr_stray_error: got %0b want 0", stray_err); end
    checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL wr_ready_after: got %0b want 1", ready_after); end
    for (int k = 0; k < 8; k++) begin
      if (k < addr_log.size()) begin
        checks++;
        if (addr_log[k] !== MEM_AW'(10'h40 + k)) begin
          errors++; $display("FAIL wr_addr[%0d]: got %h want %h", k, addr_log[k], 10'h40 + k);
        end
      end
      checks++;
      if (sram[10'h40 + k] !== wd[k]) begin
        errors++; $display("FAIL wr_sram[%0d]: got %h want %h", k, sram[10'h40 + k], wd[k]);
      end
    end
    run_req(1'b0, 32'h100, 8'd9, '0);
    checks++; if (vcycle !== 10) begin errors++; $display("FAIL rb_valid_cycle: got %0d want 10", vcycle); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rsp_rdata_o[k] !== wd[k]) begin
        errors++; $display("FAIL rb_rdata[%0d]: got %h want %h", k, rsp_rdata_o[k], wd[k]);
      end
    end
  endtask

  task automatic test_read_small;
    sram[10'h10] = 32'hAAAA_0001;
    sram[10'h11] = 32'hBBBB_0002;
    run_req(1'b0, 32'h40, 8'd3, '0);
    checks++; if (vcycle !== 4) begin errors++; $display("FAIL rd_valid_cycle: got %0d want 4", vcycle); end
    checks++; if (verr !== 1'b0) begin errors++; $display("FAIL rd_error: got %0b want 0", verr); end
    checks++; if (en_cnt !== 2) begin errors++; $display("FAIL rd_en_count: got %0d want 2", en_cnt); end
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL rd_we_count: got %0d want 0", we_cnt); end
    if (addr_log.size() >= 2) begin
      checks++; if (addr_log[0] !== 10'h10) begin errors++; $display("FAIL rd_addr0: got %h want 010", addr_log[0]); end
      checks++; if (addr_log[1] !== 10'h11) begin errors++; $display("FAIL rd_addr1: got %h want 011", addr_log[1]); end
    end
    checks++; if (rsp_rdata_o[0] !== 32'hAAAA_0001) begin errors++; $display("FAIL rd_word0: got %h want aaaa0001", rsp_rdata_o[0]); end
    checks++; if (rsp_rdata_o[1] !== 32'hBBBB_0002) begin errors++; $display("FAIL rd_word1: got %h want bbbb0002", rsp_rdata_o[1]); end
    for (int k = 2; k < 8; k++) begin
      checks++;
      if (rsp_rdata_o[k] !== 32'h0) begin errors++; $display("FAIL rd_clear[%0d]: got %h want 0", k, rsp_rdata_o[k]); end
    end
    checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL rd_ready_after: got %0b want 1", ready_after); end
  endtask

  task automatic test_errors;
    logic [31:0]      e_addr [4];
    logic [7:0]       e_size [4];
    logic [7:0][31:0] snap;
    e_addr[0] = 32'h0;               e_size[0] = 8'd5;
    e_addr[1] = 32'h42;              e_size[1] = 8'd3;
    e_addr[2] = 32'(4 * (DEPTH - 2)); e_size[2] = 8'd8;
    e_addr[3] = 32'hFFFF_FFF8;       e_size[3] = 8'd3;
    snap = rsp_rdata_o;
    for (int i = 0; i < 4; i++) begin
      run_req(i[0], e_addr[i], e_size[i], '1);
      checks++; if (vcycle !== 1) begin errors++; $display("FAIL err%0d_cycle: got %0d want 1", i, vcycle); end
      checks++; if (verr !== 1'b1) begin errors++; $display("FAIL err%0d_flag: got %0b want 1", i, verr); end
      checks++; if (en_cnt !== 0) begin errors++; $display("FAIL err%0d_mem_en: got %0d want 0", i, en_cnt); end
      checks++; if (rsp_rdata_o !== snap) begin errors++; $display("FAIL err%0d_rdata_kept: got %h want %h", i, rsp_rdata_o, snap); end
      checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL err%0d_ready: got %0b want 1", i, ready_after); end
    end
  endtask

  task automatic test_boundary;
    for (int k = 0; k < 4; k++) sram[DEPTH - 4 + k] = 32'hB0D0_0000 + k;
    run_req(1'b0, 32'(4 * (DEPTH - 4)), 8'd8, '0);
    checks++; if (vcycle !== 6) begin errors++; $display("FAIL bnd_valid_cycle: got %0d want 6", vcycle); end
    checks++; if (verr !== 1'b0) begin errors++; $display("FAIL bnd_error: got %0b want 0", verr); end
    checks++; if (en_cnt !== 4) begin errors++; $display("FAIL bnd_en_count: got %0d want 4", en_cnt); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rsp_rdata_o[k] !== ((k < 4) ? 32'hB0D0_0000 + k : 32'h0)) begin
        errors++; $display("FAIL bnd_rdata[%0d]: got %h want %h", k, rsp_rdata_o[k], (k < 4) ? 32'hB0D0_0000 + k : 32'h0);
      end
    end
  endtask

  task automatic test_back_to_back;
    int t, v1, acc, v2, en1;
    logic [7:0][31:0] buf1;
    v1 = 0; acc = 0; v2 = 0; en1 = 0; buf1 = '0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_size = 8'd9; req_wdata = '0;
    t = 0;
    while (!req_ready_o && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin req_addr = 32'h40; req_size = 8'd3; end
      if (mem_en_o) en1++;
      if (rsp_valid_o && v1 == 0) begin v1 = c; buf1 = rsp_rdata_o; end
      if (req_ready_o) begin acc = c; break; end
    end
    checks++; if (v1 !== 10) begin errors++; $display("FAIL bp_first_valid: got %0d want 10", v1); end
    checks++; if (acc !== 11) begin errors++; $display("FAIL bp_second_accept: got %0d want 11", acc); end
    checks++; if (en1 !== 8) begin errors++; $display("FAIL bp_first_en_count: got %0d want 8", en1); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (buf1[k] !== 32'hC0DE_0000 + k) begin
        errors++; $display("FAIL bp_first_rdata[%0d]: got %h want %h", k, buf1[k], 32'hC0DE_0000 + k);
      end
    end
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (rsp_valid_o) begin v2 = c; break; end
    end
    checks++; if (v2 !== 4) begin errors++; $display("FAIL bp_second_valid: got %0d want 4", v2); end
    checks++; if (rsp_error_o !== 1'b0) begin errors++; $display("FAIL bp_second_error: got %0b want 0", rsp_error_o); end
    checks++; if (rsp_rdata_o[0] !== 32'hAAAA_0001) begin errors++; $display("FAIL bp_second_word0: got %h want aaaa0001", rsp_rdata_o[0]); end
    checks++; if (rsp_rdata_o[1] !== 32'hBBBB_0002) begin errors++; $display("FAIL bp_second_word1: got %h want bbbb0002", rsp_rdata_o[1]); end
    checks++; if (rsp_rdata_o[7] !== 32'h0) begin errors++; $display("FAIL bp_second_word7: got %h want 0", rsp_rdata_o[7]); end
  endtask

  task automatic test_reset_mid;
    logic [7:0][31:0] wd;
    logic saw_valid, saw_en;
    int t;
    saw_valid = 1'b0; saw_en = 1'b0;
    for (int k = 0; k < 8; k++) begin wd[k] = 32'h5EED_0000 + k; sram[10'h80 + k] = 32'h0; end
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200; req_size = 8'd9; req_wdata = wd;
    t = 0;
    while (!req_ready_o && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
    end
    checks++;
    if (mem_en_o !== 1'b1 || mem_addr_o !== 10'h83) begin
      errors++; $display("FAIL rm_beat3: en=%0b addr=%h want en=1 addr=083", mem_en_o, mem_addr_o);
    end
    reset_n = 1'b0;
    #1;
    checks++; if (mem_en_o !== 1'b0) begin errors++; $display("FAIL rm_async_en: got %0b want 0", mem_en_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL rm_async_we: got %0b want 0", mem_we_o); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rm_ready: got %0b want 1", req_ready_o); end
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid_o) saw_valid = 1'b1;
      if (mem_en_o) saw_en = 1'b1;
    end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL rm_no_valid: got %0b want 0", saw_valid); end
    checks++; if (saw_en !== 1'b0) begin errors++; $display("FAIL rm_no_en: got %0b want 0", saw_en); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sram[10'h80 + k] !== ((k < 3) ? wd[k] : 32'h0)) begin
        errors++; $display("FAIL rm_sram[%0d]: got %h want %h", k, sram[10'h80 + k], (k < 3) ? wd[k] : 32'h0);
      end
    end
    run_req(1'b0, 32'h200, 8'd8, '0);
    checks++; if (vcycle !== 6) begin errors++; $display("FAIL rm_read_cycle: got %0d want 6", vcycle); end
    checks++; if (verr !== 1'b0) begin errors++; $display("FAIL rm_read_error: got %0b want 0", verr); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rsp_rdata_o[k] !== ((k < 3) ? wd[k] : 32'h0)) begin
        errors++; $display("FAIL rm_read[%0d]: got %h want %h", k, rsp_rdata_o[k], (k < 3) ? wd[k] : 32'h0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = 32'h0;
    test_reset();
    test_write_burst();
    test_read_small();
    test_errors();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
